// File: rtl/bcd_counter.sv
// ---------------------------------------------------------------------------
// bcd_counter
//
// Multi-digit BCD up/down counter that feeds one BCD-to-7-segment decoder per
// digit. Supports synchronous clear, parallel load with digit sanitising,
// count enable with direction, and a registered terminal-count pulse for
// cascading. Every digit presented on bcd is always a legal code 0-9.
//
// Parameters:
//   DIGITS    number of BCD digits (1-8); digit 0 is least significant.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (clears bcd, tc, load_err)
//   clr       synchronous clear, highest-priority synchronous control
//   load      synchronous parallel load of load_val
//   load_val  value to load; digit i is bits [4i+3:4i]
//   en        count enable, one step per clock while high
//   up        direction when counting: 1 = increment, 0 = decrement
//   bcd       registered count; digit i is bits [4i+3:4i]
//   tc        registered one-cycle pulse on the cycle the wrapped value shows
//   load_err  registered one-cycle flag: a loaded digit was out of range
// ---------------------------------------------------------------------------
module bcd_counter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  en,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  tc,
    output logic                  load_err
);

    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                tc_q, tc_d;
    logic                load_err_q, load_err_d;

    // Sanitised copy of load_val: any digit 10-15 is forced to 0 and flagged.
    logic [4*DIGITS-1:0] load_clean;
    logic                load_bad;

    always_comb begin
        load_clean = '0;
        load_bad   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_bad = 1'b1;
            end else begin
                load_clean[4*i +: 4] = load_val[4*i +: 4];
            end
        end
    end

    // Ripple the carry (up) or borrow (down) across all digits in one cycle.
    // A digit steps only while the chain is still live, i.e. every lower
    // digit sat at 9 (up) or 0 (down). A chain that survives the top digit
    // means the whole counter wrapped.
    logic [4*DIGITS-1:0] step_val;
    logic                chain;
    logic [3:0]          dig;

    always_comb begin
        step_val = bcd_q;
        chain    = 1'b1;
        dig      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = bcd_q[4*i +: 4];
            if (chain) begin
                if (up) begin
                    step_val[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
                    chain              = (dig == 4'd9);
                end else begin
                    step_val[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
                    chain              = (dig == 4'd0);
                end
            end
        end
    end

    // Next-state selection with priority clr > load > en > hold. tc and
    // load_err are pulses, so they default low and are only raised by the
    // single path that produces them.
    always_comb begin
        bcd_d      = bcd_q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
        if (clr) begin
            bcd_d = '0;
        end else if (load) begin
            bcd_d      = load_clean;
            load_err_d = load_bad;
        end else if (en) begin
            bcd_d = step_val;
            tc_d  = chain;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q      <= '0;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            bcd_q      <= bcd_d;
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
    end

    assign bcd      = bcd_q;
    assign tc       = tc_q;
    assign load_err = load_err_q;

endmodule
